// File: rtl/sram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package     : sram_arb_pkg
// Description : Shared types and constants for the SRAM port arbiter:
//               controller state codes, grant identifiers and the slice of
//               the CPU byte address that forms the SRAM word address.
// Revision    : 1.0  initial release
// ============================================================================
package sram_arb_pkg;

  // Byte address bits that select a 32-bit word in the SRAM
  localparam int ADDR_LSB = 2;
  localparam int ADDR_MSB = 21;
  localparam int SRAM_AW  = ADDR_MSB - ADDR_LSB + 1;

  // Access sequencer states
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_WR_SETUP = 3'd2,
    ST_WR_PULSE = 3'd3,
    ST_WR_HOLD  = 3'd4,
    ST_DONE     = 3'd5
  } arb_state_t;

  // Which CPU port owns the current access
  typedef enum logic {
    GRANT_IF = 1'b0,
    GRANT_D  = 1'b1
  } grant_t;

  // Extract the SRAM word address from a CPU byte address
  function automatic logic [SRAM_AW-1:0] word_addr(input logic [31:0] byte_addr);
    return byte_addr[ADDR_MSB:ADDR_LSB];
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface   : sram_port_arbiter_if
// Description : Bundles the two CPU request ports (instruction fetch and
//               load/store) together with the external SRAM chip pins.
//               slave  = arbiter view, master = CPU/chip side view.
// Revision    : 1.0  initial release
// ============================================================================
interface sram_port_arbiter_if;
  import sram_arb_pkg::*;

  // Instruction-fetch port
  logic               if_req;
  logic [31:0]        if_addr;
  logic [31:0]        if_rdata;
  logic               if_ack;

  // Data (load/store) port
  logic               d_req;
  logic               d_we;
  logic [31:0]        d_addr;
  logic [31:0]        d_wdata;
  logic [3:0]         d_be;
  logic [31:0]        d_rdata;
  logic               d_ack;

  // SRAM chip pins
  logic [SRAM_AW-1:0] sram_addr;
  logic [31:0]        sram_wdata;
  logic [31:0]        sram_rdata;
  logic               sram_dout_en;
  logic               sram_ce_n;
  logic               sram_oe_n;
  logic               sram_we_n;
  logic [3:0]         sram_be_n;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    input  sram_rdata,
    output if_rdata, if_ack,
    output d_rdata, d_ack,
    output sram_addr, sram_wdata, sram_dout_en,
    output sram_ce_n, sram_oe_n, sram_we_n, sram_be_n
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata, d_be,
    output sram_rdata,
    input  if_rdata, if_ack,
    input  d_rdata, d_ack,
    input  sram_addr, sram_wdata, sram_dout_en,
    input  sram_ce_n, sram_oe_n, sram_we_n, sram_be_n
  );

endinterface
`default_nettype wire

// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_port_arbiter
// Description : Shares one asynchronous 32-bit SRAM between the CPU
//               instruction-fetch and data ports. Alternates grants when
//               both ports are pending, sequences ce_n/oe_n/we_n/be_n with a
//               WAIT_CYCLES strobe width and returns a one-cycle ack.
//               All chip pins are registered so they are glitch-free.
// Revision    : 1.0  initial release
// ============================================================================
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int WAIT_CYCLES = 2   // strobe width in clocks, 1..15
) (
  input  logic               clk,
  input  logic               rst,
  sram_port_arbiter_if.slave bus
);

  // Value loaded into the wait counter when a strobe phase starts
  localparam logic [3:0] c_wait_load = 4'(WAIT_CYCLES - 1);

  // Sequencer state and grant bookkeeping
  arb_state_t         r_state;
  arb_state_t         w_next_state;
  grant_t             r_grant;
  grant_t             r_last_grant;
  grant_t             w_grant;
  logic               w_accept;

  // Wait counter
  logic [3:0]         r_wait_cnt;
  logic               w_cnt_zero;
  logic               w_cnt_load;

  // Latched access attributes
  logic [SRAM_AW-1:0] r_addr;
  logic [31:0]        r_wdata;
  logic [3:0]         r_be;
  logic [3:0]         w_be_src;

  // Returned data and acks
  logic [31:0]        r_if_rdata;
  logic [31:0]        r_d_rdata;
  logic               r_if_ack;
  logic               r_d_ack;

  // Chip control pins, decoded from the upcoming state then registered
  logic               r_ce_n;
  logic               r_oe_n;
  logic               r_we_n;
  logic               r_dout_en;
  logic [3:0]         r_be_n;
  logic               w_ce_n;
  logic               w_oe_n;
  logic               w_we_n;
  logic               w_dout_en;
  logic [3:0]         w_be_n;

  // Address bits outside the word slice carry no meaning for the chip
  logic               w_unused_bits;
  assign w_unused_bits = ^{bus.if_addr[31:ADDR_MSB+1], bus.if_addr[ADDR_LSB-1:0],
                           bus.d_addr[31:ADDR_MSB+1],  bus.d_addr[ADDR_LSB-1:0]};

  assign w_cnt_zero = (r_wait_cnt == 4'd0);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state, grant selection and pin decode for the upcoming state
  always_comb begin
    w_next_state = r_state;
    w_grant      = r_grant;
    w_accept     = 1'b0;
    w_cnt_load   = 1'b0;
    w_ce_n       = 1'b1;
    w_oe_n       = 1'b1;
    w_we_n       = 1'b1;
    w_dout_en    = 1'b0;
    w_be_n       = 4'hF;
    w_be_src     = r_be;

    case (r_state)
      ST_IDLE: begin
        if (bus.if_req || bus.d_req) begin
          w_accept = 1'b1;
          // With both ports pending, the one not served last goes first
          if (bus.if_req && bus.d_req) begin
            w_grant = (r_last_grant == GRANT_IF) ? GRANT_D : GRANT_IF;
          end else if (bus.d_req) begin
            w_grant = GRANT_D;
          end else begin
            w_grant = GRANT_IF;
          end
          w_next_state = ((w_grant == GRANT_D) && bus.d_we) ? ST_WR_SETUP : ST_RD;
        end
      end
      ST_RD: begin
        if (w_cnt_zero) begin
          w_next_state = ST_DONE;
        end
      end
      ST_WR_SETUP: begin
        w_next_state = ST_WR_PULSE;
      end
      ST_WR_PULSE: begin
        if (w_cnt_zero) begin
          w_next_state = ST_WR_HOLD;
        end
      end
      ST_WR_HOLD: begin
        w_next_state = ST_DONE;
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase

    // The counter restarts whenever a strobe phase is entered
    w_cnt_load = (w_next_state != r_state) &&
                 ((w_next_state == ST_RD) || (w_next_state == ST_WR_PULSE));

    // On the accept edge the byte enables are not latched yet
    if (w_accept) begin
      w_be_src = bus.d_be;
    end

    case (w_next_state)
      ST_RD: begin
        w_ce_n = 1'b0;
        w_oe_n = 1'b0;
        w_be_n = 4'h0;
      end
      ST_WR_SETUP, ST_WR_HOLD: begin
        w_ce_n    = 1'b0;
        w_dout_en = 1'b1;
        w_be_n    = ~w_be_src;
      end
      ST_WR_PULSE: begin
        w_ce_n    = 1'b0;
        w_we_n    = 1'b0;
        w_dout_en = 1'b1;
        w_be_n    = ~w_be_src;
      end
      default: begin
        w_ce_n = 1'b1;
      end
    endcase
  end

  // Wait counter: loaded on strobe entry, counts down to zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= 4'd0;
    end else if (w_cnt_load) begin
      r_wait_cnt <= c_wait_load;
    end else if (!w_cnt_zero &&
                 ((r_state == ST_RD) || (r_state == ST_WR_PULSE))) begin
      r_wait_cnt <= r_wait_cnt - 4'd1;
    end
  end

  // Latch grant and access attributes on accept; track last served port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant      <= GRANT_IF;
      r_last_grant <= GRANT_IF;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_be         <= '0;
    end else begin
      if (w_accept) begin
        r_grant <= w_grant;
        r_addr  <= word_addr((w_grant == GRANT_D) ? bus.d_addr : bus.if_addr);
        if (w_grant == GRANT_D) begin
          r_wdata <= bus.d_wdata;
          r_be    <= bus.d_be;
        end
      end
      if (r_state == ST_DONE) begin
        r_last_grant <= r_grant;
      end
    end
  end

  // Capture read data at the end of the last read strobe cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else if ((r_state == ST_RD) && w_cnt_zero) begin
      if (r_grant == GRANT_IF) begin
        r_if_rdata <= bus.sram_rdata;
      end else begin
        r_d_rdata  <= bus.sram_rdata;
      end
    end
  end

  // Register chip controls and the single-cycle acks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ce_n    <= 1'b1;
      r_oe_n    <= 1'b1;
      r_we_n    <= 1'b1;
      r_dout_en <= 1'b0;
      r_be_n    <= 4'hF;
      r_if_ack  <= 1'b0;
      r_d_ack   <= 1'b0;
    end else begin
      r_ce_n    <= w_ce_n;
      r_oe_n    <= w_oe_n;
      r_we_n    <= w_we_n;
      r_dout_en <= w_dout_en;
      r_be_n    <= w_be_n;
      r_if_ack  <= (w_next_state == ST_DONE) && (w_grant == GRANT_IF);
      r_d_ack   <= (w_next_state == ST_DONE) && (w_grant == GRANT_D);
    end
  end

  assign bus.sram_addr    = r_addr;
  assign bus.sram_wdata   = r_wdata;
  assign bus.sram_ce_n    = r_ce_n;
  assign bus.sram_oe_n    = r_oe_n;
  assign bus.sram_we_n    = r_we_n;
  assign bus.sram_be_n    = r_be_n;
  assign bus.sram_dout_en = r_dout_en;
  assign bus.if_rdata     = r_if_rdata;
  assign bus.if_ack       = r_if_ack;
  assign bus.d_rdata      = r_d_rdata;
  assign bus.d_ack        = r_d_ack;

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_port_arbiter
// Description : Self-checking bench for sram_port_arbiter. A WAIT_CYCLES=2
//               instance talks to a behavioural SRAM chip and is compared
//               against a reference memory and a grant/latency model; a
//               WAIT_CYCLES=1 instance checks the short-strobe latencies.
// Revision    : 1.0  initial release
// ============================================================================
module tb_sram_port_arbiter;
  import sram_arb_pkg::*;

  localparam int W  = 2;
  localparam int W1 = 1;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  int     total = 0;
  int     bad   = 0;
  bit     mon_on = 1'b0;
  grant_t m_last = GRANT_IF;
  grant_t last_served = GRANT_IF;

  logic [31:0] chip_mem [0:255];
  logic [31:0] ref_mem  [0:255];

  sram_port_arbiter_if bus  ();
  sram_port_arbiter_if bus1 ();

  sram_port_arbiter #(.WAIT_CYCLES(W))  dut  (.clk(clk), .rst(rst), .bus(bus));
  sram_port_arbiter #(.WAIT_CYCLES(W1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  // Asynchronous SRAM: combinational read, byte-masked write while we_n low
  assign bus.sram_rdata  = chip_mem[bus.sram_addr[7:0]];
  assign bus1.sram_rdata = 32'hC0DE_0000 ^ {12'h0, bus1.sram_addr};

  always @(negedge clk) begin
    if (!bus.sram_ce_n && !bus.sram_we_n && bus.sram_dout_en) begin
      for (int b = 0; b < 4; b++) begin
        if (!bus.sram_be_n[b]) chip_mem[bus.sram_addr[7:0]][8*b +: 8] <= bus.sram_wdata[8*b +: 8];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Bus-contention and double-ack monitor
  always @(negedge clk) begin
    if (mon_on && !rst) begin
      check("oe_dout_overlap", 32'(bus.sram_dout_en & ~bus.sram_oe_n), 32'd0);
      check("dual_ack", 32'(bus.if_ack & bus.d_ack), 32'd0);
    end
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] rnd_addr();
    logic [31:0] r;
    r = $urandom;
    return (r & 32'hFFC0_0003) | (32'($urandom_range(0, 127)) << 2);
  endfunction

  // One transaction on the main instance. Called just after a rising edge
  // with the DUT idle and requests already driven.
  task automatic serve();
    grant_t      g;
    bit          wr, got, got_if, addr_ok;
    logic [19:0] ea;
    logic [31:0] erd, ewd, ord, swd;
    logic [3:0]  ebe, ebe_n, sbe;
    int          elat, lat, oe_c, we_c, ce_c, de_c;
    got = 0; got_if = 0; addr_ok = 1; lat = 0;
    oe_c = 0; we_c = 0; ce_c = 0; de_c = 0;
    ord = '0; swd = '0; sbe = 4'hF;
    if (bus.if_req && bus.d_req) g = (m_last == GRANT_IF) ? GRANT_D : GRANT_IF;
    else if (bus.d_req)          g = GRANT_D;
    else                         g = GRANT_IF;
    wr    = (g == GRANT_D) && bus.d_we;
    ea    = (g == GRANT_D) ? bus.d_addr[21:2] : bus.if_addr[21:2];
    ewd   = bus.d_wdata;
    ebe   = bus.d_be;
    ebe_n = ~ebe;
    erd   = ref_mem[ea[7:0]];
    elat  = wr ? W + 3 : W + 1;
    @(negedge clk);
    check("ack_idle", {30'd0, bus.if_ack, bus.d_ack}, 32'd0);
    @(posedge clk);
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge clk);
      if (!bus.sram_ce_n) begin
        ce_c++;
        if (bus.sram_addr !== ea) addr_ok = 0;
      end
      if (!bus.sram_oe_n) begin oe_c++; sbe = bus.sram_be_n; end
      if (!bus.sram_we_n) begin we_c++; sbe = bus.sram_be_n; swd = bus.sram_wdata; end
      if (bus.sram_dout_en) de_c++;
      if (bus.if_ack || bus.d_ack) begin
        got = 1; lat = k; got_if = bus.if_ack;
        ord = bus.if_ack ? bus.if_rdata : bus.d_rdata;
      end
    end
    check("ack_seen", 32'(got), 32'd1);
    if (got) begin
      check("grant",       32'(got_if), 32'(g == GRANT_IF));
      check("latency",     lat, elat);
      check("addr",        32'(addr_ok), 32'd1);
      check("ce_cycles",   ce_c, wr ? W + 2 : W);
      check("oe_cycles",   oe_c, wr ? 0 : W);
      check("we_cycles",   we_c, wr ? W : 0);
      check("dout_cycles", de_c, wr ? W + 2 : 0);
      check("be_n",        32'(sbe), wr ? 32'(ebe_n) : 32'd0);
      if (wr) check("wdata", swd, ewd);
      else    check("rdata", ord, erd);
    end
    last_served = got_if ? GRANT_IF : GRANT_D;
    if (wr) ref_mem[ea[7:0]] = merge(ref_mem[ea[7:0]], ewd, ebe);
    m_last = g;
    @(posedge clk); #1;
    if (g == GRANT_D) bus.d_req = 1'b0;
    else              bus.if_req = 1'b0;
  endtask

  // Latency of one access on the WAIT_CYCLES=1 instance
  task automatic lat1(output int l);
    l = -1;
    @(posedge clk);
    for (int k = 1; k <= 20 && l < 0; k++) begin
      @(negedge clk);
      if (bus1.if_ack || bus1.d_ack) l = k;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int l;
    bus.if_req = 0;  bus.if_addr = '0;
    bus.d_req = 0;   bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0;
    bus1.if_req = 0; bus1.if_addr = '0;
    bus1.d_req = 0;  bus1.d_we = 0; bus1.d_addr = '0; bus1.d_wdata = '0; bus1.d_be = '0;
    for (int i = 0; i < 256; i++) begin
      chip_mem[i] = $urandom;
      ref_mem[i]  = chip_mem[i];
    end
    chip_mem[8'h04] = 32'h1234_5678; ref_mem[8'h04] = 32'h1234_5678;
    chip_mem[8'h40] = 32'h1122_3344; ref_mem[8'h40] = 32'h1122_3344;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ce_n",   32'(bus.sram_ce_n), 32'd1);
    check("rst_oe_n",   32'(bus.sram_oe_n), 32'd1);
    check("rst_we_n",   32'(bus.sram_we_n), 32'd1);
    check("rst_be_n",   32'(bus.sram_be_n), 32'hF);
    check("rst_dout",   32'(bus.sram_dout_en), 32'd0);
    check("rst_addr",   32'(bus.sram_addr), 32'd0);
    check("rst_wdata",  bus.sram_wdata, 32'd0);
    check("rst_acks",   {30'd0, bus.if_ack, bus.d_ack}, 32'd0);
    check("rst_if_rd",  bus.if_rdata, 32'd0);
    check("rst_d_rd",   bus.d_rdata, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    mon_on = 1'b1;

    // IF read of word 4
    bus.if_req = 1; bus.if_addr = 32'h0000_0010;
    serve();
    check("t1_if_rdata_held", bus.if_rdata, 32'h1234_5678);

    // Data write with lower two byte lanes, then read back
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h0000_0100;
    bus.d_wdata = 32'hDEAD_BEEF; bus.d_be = 4'b0011;
    serve();
    check("t2_chip_word", chip_mem[8'h40], 32'h1122_BEEF);
    bus.d_req = 1; bus.d_we = 0;
    serve();
    check("t2_readback", bus.d_rdata, 32'h1122_BEEF);

    // Back-to-back IF reads
    bus.if_req = 1; bus.if_addr = 32'h0000_0000;
    serve();
    bus.if_req = 1; bus.if_addr = 32'h0000_0004;
    serve();

    // Reset during the second write-strobe cycle
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h0000_03FC;
    bus.d_wdata = 32'hA5A5_5A5A; bus.d_be = 4'hF;
    @(posedge clk);
    @(negedge clk);
    check("mid_setup_dout", 32'(bus.sram_dout_en), 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("mid_pulse_we", 32'(bus.sram_we_n), 32'd0);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_we_n", 32'(bus.sram_we_n), 32'd1);
    check("mid_rst_dout", 32'(bus.sram_dout_en), 32'd0);
    check("mid_rst_ce_n", 32'(bus.sram_ce_n), 32'd1);
    check("mid_rst_ack",  32'(bus.d_ack), 32'd0);
    bus.d_req = 0;
    @(posedge clk); #2 rst = 1'b0;
    m_last = GRANT_IF;
    @(negedge clk);
    check("mid_state_idle", 32'(dut.r_state), 32'(ST_IDLE));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_no_ack", 32'(bus.d_ack), 32'd0);
    end
    @(posedge clk); #1;

    // Both ports held across three transactions: D, IF, D
    bus.if_req = 1; bus.if_addr = 32'h0000_0020;
    bus.d_req = 1;  bus.d_we = 0; bus.d_addr = 32'h0000_0030;
    serve();
    check("arb_first",  32'(last_served), 32'(GRANT_D));
    bus.d_req = 1;
    serve();
    check("arb_second", 32'(last_served), 32'(GRANT_IF));
    bus.if_req = 1;
    serve();
    check("arb_third",  32'(last_served), 32'(GRANT_D));
    bus.if_req = 0;

    // Short-strobe instance latencies
    bus1.if_req = 1; bus1.if_addr = 32'h0000_0020;
    lat1(l);
    check("w1_rd_lat", l, 2);
    check("w1_rdata", bus1.if_rdata, 32'hC0DE_0008);
    bus1.if_req = 0;
    bus1.d_req = 1; bus1.d_we = 1; bus1.d_addr = 32'h0000_0040;
    bus1.d_wdata = 32'h0BAD_F00D; bus1.d_be = 4'hF;
    lat1(l);
    check("w1_wr_lat", l, 4);
    bus1.d_req = 0;

    // Randomized request mix against the reference model
    for (int it = 0; it < 40; it++) begin
      if (!bus.if_req && ($urandom_range(0, 1) == 1)) begin
        bus.if_req = 1; bus.if_addr = rnd_addr();
      end
      if (!bus.d_req && ($urandom_range(0, 1) == 1)) begin
        bus.d_req = 1; bus.d_we = 1'($urandom_range(0, 1)); bus.d_addr = rnd_addr();
        bus.d_wdata = $urandom; bus.d_be = 4'($urandom_range(0, 15));
      end
      if (!bus.if_req && !bus.d_req) begin
        bus.if_req = 1; bus.if_addr = rnd_addr();
      end
      serve();
    end
    bus.if_req = 0; bus.d_req = 0;
    repeat (4) @(posedge clk);
    mon_on = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
